axi_write_arbiter: RTL and testbench

AXI_WRITE_ARBITER -- requirements
Module: axi_write_arbiter

---
 rtl/axi_write_arbiter_if.sv | 56 +++++
 rtl/axi_write_arbiter.sv | 121 ++++++++++++
 tb/tb_axi_write_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_write_arbiter_if.sv
// Bundle of the two master write channels, the shared slave channel and the
// arbiter status outputs. The slave modport is the arbiter's view.
interface axi_write_arbiter_if #(
    parameter int LEN_W = 8
) ();
    logic             M0_AWVALID;
    logic [LEN_W-1:0] M0_AWLEN;
    logic             M0_AWREADY;
    logic             M0_WVALID;
    logic             M0_WLAST;
    logic             M0_WREADY;
    logic             M0_BREADY;
    logic             M0_BVALID;

    logic             M1_AWVALID;
    logic [LEN_W-1:0] M1_AWLEN;
    logic             M1_AWREADY;
    logic             M1_WVALID;
    logic             M1_WLAST;
    logic             M1_WREADY;
    logic             M1_BREADY;
    logic             M1_BVALID;

    logic             S_AWVALID;
    logic             S_AWREADY;
    logic             S_WVALID;
    logic             S_WLAST;
    logic             S_WREADY;
    logic             S_BVALID;
    logic             S_BREADY;

    logic             Sel;
    logic             Busy;
    logic [LEN_W:0]   Beat_Cnt;
    logic             Len_Err;

    modport slave (
        input  M0_AWVALID, M0_AWLEN, M0_WVALID, M0_WLAST, M0_BREADY,
        input  M1_AWVALID, M1_AWLEN, M1_WVALID, M1_WLAST, M1_BREADY,
        input  S_AWREADY, S_WREADY, S_BVALID,
        output M0_AWREADY, M0_WREADY, M0_BVALID,
        output M1_AWREADY, M1_WREADY, M1_BVALID,
        output S_AWVALID, S_WVALID, S_WLAST, S_BREADY,
        output Sel, Busy, Beat_Cnt, Len_Err
    );

    modport master (
        output M0_AWVALID, M0_AWLEN, M0_WVALID, M0_WLAST, M0_BREADY,
        output M1_AWVALID, M1_AWLEN, M1_WVALID, M1_WLAST, M1_BREADY,
        output S_AWREADY, S_WREADY, S_BVALID,
        input  M0_AWREADY, M0_WREADY, M0_BVALID,
        input  M1_AWREADY, M1_WREADY, M1_BVALID,
        input  S_AWVALID, S_WVALID, S_WLAST, S_BREADY,
        input  Sel, Busy, Beat_Cnt, Len_Err
    );
endinterface

// File: rtl/axi_write_arbiter.sv
// Two-master AXI write arbiter: one master owns a whole AW/W/B transaction,
// with round-robin on simultaneous requests and a WLAST/AWLEN consistency check.
module axi_write_arbiter #(
    parameter int LEN_W = 8
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    axi_write_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t           state, state_nxt;
    logic             sel, sel_nxt;
    logic             rr, rr_nxt;
    logic [LEN_W-1:0] len_q, len_nxt;
    logic [LEN_W:0]   beat_cnt, beat_nxt;
    logic             len_err, len_err_nxt;

    logic own_awvalid, own_wvalid, own_wlast, own_bready;
    logic aw_ready, w_ready, b_valid;
    logic s_awvalid, s_wvalid, s_wlast, s_bready;
    logic w_hs;

    // Owner-side inputs depend only on the registered select, never on the other master.
    assign own_awvalid = sel ? bus.M1_AWVALID : bus.M0_AWVALID;
    assign own_wvalid  = sel ? bus.M1_WVALID  : bus.M0_WVALID;
    assign own_wlast   = sel ? bus.M1_WLAST   : bus.M0_WLAST;
    assign own_bready  = sel ? bus.M1_BREADY  : bus.M0_BREADY;
    assign w_hs        = (state == DATA) && own_wvalid && bus.S_WREADY;

    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        rr_nxt      = rr;
        len_nxt     = len_q;
        beat_nxt    = beat_cnt;
        len_err_nxt = 1'b0;
        aw_ready    = 1'b0;
        w_ready     = 1'b0;
        b_valid     = 1'b0;
        s_awvalid   = 1'b0;
        s_wvalid    = 1'b0;
        s_wlast     = 1'b0;
        s_bready    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.M0_AWVALID || bus.M1_AWVALID) begin
                    sel_nxt   = (bus.M0_AWVALID && bus.M1_AWVALID) ? rr : bus.M1_AWVALID;
                    len_nxt   = sel_nxt ? bus.M1_AWLEN : bus.M0_AWLEN;
                    beat_nxt  = '0;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                s_awvalid = own_awvalid;
                aw_ready  = bus.S_AWREADY;
                if (own_awvalid && bus.S_AWREADY) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                s_wvalid = own_wvalid;
                s_wlast  = own_wlast;
                w_ready  = bus.S_WREADY;
                if (w_hs) begin
                    if (beat_cnt != '1) begin
                        beat_nxt = beat_cnt + 1'b1;
                    end
                    // beat_cnt still holds the beats before this one, so a matching WLAST sees beat_cnt == AWLEN.
                    len_err_nxt = own_wlast ? (beat_cnt != {1'b0, len_q})
                                            : (beat_cnt == {1'b0, len_q});
                    if (own_wlast) begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                b_valid  = bus.S_BVALID;
                s_bready = own_bready;
                if (bus.S_BVALID && own_bready) begin
                    state_nxt = IDLE;
                    rr_nxt    = ~sel;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state    <= IDLE;
            sel      <= 1'b0;
            rr       <= 1'b0;
            len_q    <= '0;
            beat_cnt <= '0;
            len_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            rr       <= rr_nxt;
            len_q    <= len_nxt;
            beat_cnt <= beat_nxt;
            len_err  <= len_err_nxt;
        end
    end

    assign bus.M0_AWREADY = aw_ready & ~sel;
    assign bus.M1_AWREADY = aw_ready &  sel;
    assign bus.M0_WREADY  = w_ready  & ~sel;
    assign bus.M1_WREADY  = w_ready  &  sel;
    assign bus.M0_BVALID  = b_valid  & ~sel;
    assign bus.M1_BVALID  = b_valid  &  sel;
    assign bus.S_AWVALID  = s_awvalid;
    assign bus.S_WVALID   = s_wvalid;
    assign bus.S_WLAST    = s_wlast;
    assign bus.S_BREADY   = s_bready;
    assign bus.Sel        = sel;
    assign bus.Busy       = (state != IDLE);
    assign bus.Beat_Cnt   = beat_cnt;
    assign bus.Len_Err    = len_err;
endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: inputs change and outputs are sampled
// just after the falling edge, state advances on the rising edge.
module tb_axi_write_arbiter;
    logic ACLK;
    logic ARESETN;
    int   vectors;
    int   miscompares;
    int   beats;
    logic hs;

    axi_write_arbiter_if #(.LEN_W(8)) bus ();

    axi_write_arbiter #(.LEN_W(8)) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .bus     (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic clear_inputs();
        bus.M0_AWVALID = 1'b0; bus.M0_AWLEN = 8'd0; bus.M0_WVALID = 1'b0;
        bus.M0_WLAST   = 1'b0; bus.M0_BREADY = 1'b0;
        bus.M1_AWVALID = 1'b0; bus.M1_AWLEN = 8'd0; bus.M1_WVALID = 1'b0;
        bus.M1_WLAST   = 1'b0; bus.M1_BREADY = 1'b0;
        bus.S_AWREADY  = 1'b0; bus.S_WREADY = 1'b0; bus.S_BVALID = 1'b0;
    endtask

    // Request from IDLE, complete the AW handshake, return just after entering DATA.
    task automatic start_txn(input logic r0, input logic r1,
                             input logic [7:0] l0, input logic [7:0] l1);
        @(negedge ACLK);
        bus.M0_AWVALID = r0; bus.M1_AWVALID = r1;
        bus.M0_AWLEN   = l0; bus.M1_AWLEN   = l1;
        @(negedge ACLK);
        bus.S_AWREADY = 1'b1;
        @(negedge ACLK);
        clear_inputs();
        #1;
    endtask

    task automatic finish_resp();
        bus.S_BVALID = 1'b1; bus.M0_BREADY = 1'b1; bus.M1_BREADY = 1'b1;
        @(negedge ACLK);
        clear_inputs();
        #1;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        clear_inputs();
        @(negedge ACLK);
        @(negedge ACLK);
        bus.M0_AWVALID = 1'b1; bus.M1_AWVALID = 1'b1; bus.S_AWREADY = 1'b1;
        bus.S_WREADY = 1'b1; bus.S_BVALID = 1'b1; bus.M0_BREADY = 1'b1;
        bus.M1_BREADY = 1'b1; bus.M0_WVALID = 1'b1; bus.M1_WVALID = 1'b1;
        #1;
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
        vectors++; if (bus.Sel !== 1'b0) begin miscompares++; $display("FAIL reset_sel: got %b want 0", bus.Sel); end
        vectors++; if (bus.Beat_Cnt !== 9'd0) begin miscompares++; $display("FAIL reset_beat_cnt: got %0d want 0", bus.Beat_Cnt); end
        vectors++; if (bus.Len_Err !== 1'b0) begin miscompares++; $display("FAIL reset_len_err: got %b want 0", bus.Len_Err); end
        vectors++;
        if ({bus.M0_AWREADY, bus.M1_AWREADY, bus.M0_WREADY, bus.M1_WREADY, bus.M0_BVALID,
             bus.M1_BVALID, bus.S_AWVALID, bus.S_WVALID, bus.S_WLAST, bus.S_BREADY} !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_handshakes: got %b want 0000000000",
                     {bus.M0_AWREADY, bus.M1_AWREADY, bus.M0_WREADY, bus.M1_WREADY, bus.M0_BVALID,
                      bus.M1_BVALID, bus.S_AWVALID, bus.S_WVALID, bus.S_WLAST, bus.S_BREADY});
        end
        @(negedge ACLK);
        #1;
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL reset_held_busy: got %b want 0", bus.Busy); end
        ARESETN = 1'b1;
        clear_inputs();
    endtask

    task automatic test_round_robin();
        @(negedge ACLK);
        bus.M0_AWVALID = 1'b1; bus.M1_AWVALID = 1'b1;
        #1;
        vectors++; if (bus.S_AWVALID !== 1'b0) begin miscompares++; $display("FAIL rr_idle_no_grant: got %b want 0", bus.S_AWVALID); end
        @(negedge ACLK);
        bus.S_AWREADY = 1'b1;
        #1;
        vectors++; if (bus.Sel !== 1'b0) begin miscompares++; $display("FAIL rr_first_sel: got %b want 0", bus.Sel); end
        vectors++; if (bus.M0_AWREADY !== 1'b1) begin miscompares++; $display("FAIL rr_m0_awready: got %b want 1", bus.M0_AWREADY); end
        vectors++; if (bus.M1_AWREADY !== 1'b0) begin miscompares++; $display("FAIL rr_m1_awready_addr: got %b want 0", bus.M1_AWREADY); end
        @(negedge ACLK);
        bus.M0_AWVALID = 1'b0; bus.S_AWREADY = 1'b0;
        bus.M0_WVALID = 1'b1; bus.M0_WLAST = 1'b1; bus.S_WREADY = 1'b1;
        #1;
        vectors++; if (bus.M0_WREADY !== 1'b1) begin miscompares++; $display("FAIL rr_m0_wready: got %b want 1", bus.M0_WREADY); end
        vectors++; if (bus.M1_WREADY !== 1'b0) begin miscompares++; $display("FAIL rr_m1_wready: got %b want 0", bus.M1_WREADY); end
        vectors++; if (bus.M1_AWREADY !== 1'b0) begin miscompares++; $display("FAIL rr_m1_awready_data: got %b want 0", bus.M1_AWREADY); end
        @(negedge ACLK);
        bus.M0_WVALID = 1'b0; bus.M0_WLAST = 1'b0; bus.S_WREADY = 1'b0;
        bus.S_BVALID = 1'b1; bus.M0_BREADY = 1'b1; bus.M1_BREADY = 1'b1;
        #1;
        vectors++; if (bus.M0_BVALID !== 1'b1) begin miscompares++; $display("FAIL rr_m0_bvalid: got %b want 1", bus.M0_BVALID); end
        vectors++; if (bus.M1_BVALID !== 1'b0) begin miscompares++; $display("FAIL rr_m1_bvalid: got %b want 0", bus.M1_BVALID); end
        @(negedge ACLK);
        bus.S_BVALID = 1'b0; bus.M0_BREADY = 1'b0; bus.M1_BREADY = 1'b0;
        bus.M0_AWVALID = 1'b1;
        #1;
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL rr_idle_gap: got %b want 0", bus.Busy); end
        @(negedge ACLK);
        bus.S_AWREADY = 1'b1;
        #1;
        vectors++; if (bus.Sel !== 1'b1) begin miscompares++; $display("FAIL rr_second_sel: got %b want 1", bus.Sel); end
        vectors++; if (bus.M0_AWREADY !== 1'b0) begin miscompares++; $display("FAIL rr_m0_awready_nonowner: got %b want 0", bus.M0_AWREADY); end
        vectors++; if (bus.M1_AWREADY !== 1'b1) begin miscompares++; $display("FAIL rr_m1_awready: got %b want 1", bus.M1_AWREADY); end
        @(negedge ACLK);
        clear_inputs();
        bus.M1_WVALID = 1'b1; bus.M1_WLAST = 1'b1; bus.S_WREADY = 1'b1; bus.M0_WVALID = 1'b1;
        #1;
        vectors++; if (bus.M0_WREADY !== 1'b0) begin miscompares++; $display("FAIL rr_m0_wready_nonowner: got %b want 0", bus.M0_WREADY); end
        @(negedge ACLK);
        clear_inputs();
        bus.S_BVALID = 1'b1; bus.M1_BREADY = 1'b1;
        #1;
        vectors++; if (bus.M1_BVALID !== 1'b1) begin miscompares++; $display("FAIL rr_m1_bvalid_owner: got %b want 1", bus.M1_BVALID); end
        @(negedge ACLK);
        clear_inputs();
    endtask

    task automatic test_single_m0();
        start_txn(1'b1, 1'b0, 8'd0, 8'd5);
        vectors++; if (bus.Sel !== 1'b0) begin miscompares++; $display("FAIL single_sel: got %b want 0", bus.Sel); end
        bus.M0_WVALID = 1'b1; bus.M0_WLAST = 1'b1; bus.S_WREADY = 1'b1;
        #1;
        vectors++; if (bus.S_WLAST !== 1'b1) begin miscompares++; $display("FAIL single_s_wlast: got %b want 1", bus.S_WLAST); end
        @(negedge ACLK);
        clear_inputs();
        #1;
        vectors++; if (bus.Beat_Cnt !== 9'd1) begin miscompares++; $display("FAIL single_beat_cnt: got %0d want 1", bus.Beat_Cnt); end
        vectors++; if (bus.Len_Err !== 1'b0) begin miscompares++; $display("FAIL single_len_err: got %b want 0", bus.Len_Err); end
        finish_resp();
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL single_back_idle: got %b want 0", bus.Busy); end
    endtask

    task automatic test_burst_m1();
        start_txn(1'b1, 1'b1, 8'd9, 8'd3);
        vectors++; if (bus.Sel !== 1'b1) begin miscompares++; $display("FAIL burst_rr_sel: got %b want 1", bus.Sel); end
        beats = 0;
        for (int i = 0; i < 10 && beats < 4; i++) begin
            bus.M1_WVALID = 1'b1;
            bus.M1_WLAST  = (beats == 3);
            bus.S_WREADY  = (i % 2 == 0);
            hs = bus.S_WREADY;
            @(negedge ACLK);
            #1;
            if (hs) beats++;
            vectors++; if (bus.Beat_Cnt !== 9'(beats)) begin miscompares++; $display("FAIL burst_beat_cnt_%0d: got %0d want %0d", i, bus.Beat_Cnt, beats); end
            vectors++; if (bus.Len_Err !== 1'b0) begin miscompares++; $display("FAIL burst_len_err_%0d: got %b want 0", i, bus.Len_Err); end
        end
        bus.S_WREADY = 1'b1; bus.M1_BREADY = 1'b1;
        #1;
        vectors++; if (bus.S_WVALID !== 1'b0) begin miscompares++; $display("FAIL burst_in_resp: got %b want 0", bus.S_WVALID); end
        vectors++; if (bus.S_BREADY !== 1'b1) begin miscompares++; $display("FAIL burst_s_bready: got %b want 1", bus.S_BREADY); end
        vectors++; if (bus.M1_BVALID !== 1'b0) begin miscompares++; $display("FAIL burst_m1_bvalid_low: got %b want 0", bus.M1_BVALID); end
        clear_inputs();
        finish_resp();
    endtask

    task automatic test_len_short();
        start_txn(1'b1, 1'b0, 8'd3, 8'd0);
        bus.M0_WVALID = 1'b1; bus.S_WREADY = 1'b1;
        @(negedge ACLK);
        #1;
        vectors++; if (bus.Len_Err !== 1'b0) begin miscompares++; $display("FAIL short_beat1_err: got %b want 0", bus.Len_Err); end
        bus.M0_WLAST = 1'b1;
        @(negedge ACLK);
        #1;
        vectors++; if (bus.Len_Err !== 1'b1) begin miscompares++; $display("FAIL short_len_err: got %b want 1", bus.Len_Err); end
        vectors++; if (bus.Beat_Cnt !== 9'd2) begin miscompares++; $display("FAIL short_beat_cnt: got %0d want 2", bus.Beat_Cnt); end
        vectors++; if (bus.S_WVALID !== 1'b0) begin miscompares++; $display("FAIL short_in_resp: got %b want 0", bus.S_WVALID); end
        clear_inputs();
        @(negedge ACLK);
        #1;
        vectors++; if (bus.Len_Err !== 1'b0) begin miscompares++; $display("FAIL short_pulse_width: got %b want 0", bus.Len_Err); end
        vectors++; if (bus.Busy !== 1'b1) begin miscompares++; $display("FAIL short_resp_busy: got %b want 1", bus.Busy); end
        finish_resp();
    endtask

    task automatic test_len_long();
        start_txn(1'b1, 1'b0, 8'd1, 8'd0);
        bus.M0_WVALID = 1'b1; bus.S_WREADY = 1'b1;
        @(negedge ACLK);
        #1;
        vectors++; if (bus.Len_Err !== 1'b0) begin miscompares++; $display("FAIL long_beat1_err: got %b want 0", bus.Len_Err); end
        @(negedge ACLK);
        #1;
        vectors++; if (bus.Len_Err !== 1'b1) begin miscompares++; $display("FAIL long_len_err: got %b want 1", bus.Len_Err); end
        vectors++; if (bus.S_WVALID !== 1'b1) begin miscompares++; $display("FAIL long_still_data: got %b want 1", bus.S_WVALID); end
        bus.S_WREADY = 1'b0; bus.M0_WLAST = 1'b1;
        @(negedge ACLK);
        #1;
        vectors++; if (bus.Len_Err !== 1'b0) begin miscompares++; $display("FAIL long_pulse_width: got %b want 0", bus.Len_Err); end
        vectors++; if (bus.S_WVALID !== 1'b1) begin miscompares++; $display("FAIL long_wlast_no_hs: got %b want 1", bus.S_WVALID); end
        bus.S_WREADY = 1'b1;
        @(negedge ACLK);
        #1;
        vectors++; if (bus.Len_Err !== 1'b1) begin miscompares++; $display("FAIL long_late_last_err: got %b want 1", bus.Len_Err); end
        vectors++; if (bus.Beat_Cnt !== 9'd3) begin miscompares++; $display("FAIL long_beat_cnt: got %0d want 3", bus.Beat_Cnt); end
        vectors++; if (bus.S_WVALID !== 1'b0) begin miscompares++; $display("FAIL long_in_resp: got %b want 0", bus.S_WVALID); end
        clear_inputs();
        finish_resp();
    endtask

    task automatic test_saturate();
        start_txn(1'b1, 1'b0, 8'd0, 8'd0);
        bus.M0_WVALID = 1'b1; bus.S_WREADY = 1'b1;
        repeat (515) @(negedge ACLK);
        #1;
        vectors++; if (bus.Beat_Cnt !== 9'h1FF) begin miscompares++; $display("FAIL sat_beat_cnt: got %0d want 511", bus.Beat_Cnt); end
        vectors++; if (bus.S_WVALID !== 1'b1) begin miscompares++; $display("FAIL sat_still_data: got %b want 1", bus.S_WVALID); end
        bus.M0_WLAST = 1'b1;
        @(negedge ACLK);
        clear_inputs();
        #1;
        vectors++; if (bus.Beat_Cnt !== 9'h1FF) begin miscompares++; $display("FAIL sat_no_wrap: got %0d want 511", bus.Beat_Cnt); end
        finish_resp();
    endtask

    task automatic test_reset_mid();
        start_txn(1'b1, 1'b1, 8'd2, 8'd2);
        vectors++; if (bus.Sel !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_sel: got %b want 1", bus.Sel); end
        bus.M1_WVALID = 1'b1; bus.S_WREADY = 1'b1;
        @(negedge ACLK);
        ARESETN = 1'b0;
        bus.S_AWREADY = 1'b1; bus.S_BVALID = 1'b1; bus.M1_BREADY = 1'b1;
        @(negedge ACLK);
        #1;
        vectors++; if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", bus.Busy); end
        vectors++; if (bus.Sel !== 1'b0) begin miscompares++; $display("FAIL midrst_sel: got %b want 0", bus.Sel); end
        vectors++; if (bus.Beat_Cnt !== 9'd0) begin miscompares++; $display("FAIL midrst_beat_cnt: got %0d want 0", bus.Beat_Cnt); end
        vectors++;
        if ({bus.M1_AWREADY, bus.M1_WREADY, bus.M1_BVALID, bus.S_WVALID, bus.S_AWVALID, bus.S_BREADY} !== 6'd0) begin
            miscompares++;
            $display("FAIL midrst_outputs: got %b want 000000",
                     {bus.M1_AWREADY, bus.M1_WREADY, bus.M1_BVALID, bus.S_WVALID, bus.S_AWVALID, bus.S_BREADY});
        end
        ARESETN = 1'b1;
        clear_inputs();
        bus.M0_AWVALID = 1'b1; bus.M1_AWVALID = 1'b1; bus.S_AWREADY = 1'b1;
        @(negedge ACLK);
        #1;
        vectors++; if (bus.Sel !== 1'b0) begin miscompares++; $display("FAIL midrst_regrant_sel: got %b want 0", bus.Sel); end
        vectors++; if (bus.M1_AWREADY !== 1'b0) begin miscompares++; $display("FAIL midrst_m1_awready: got %b want 0", bus.M1_AWREADY); end
        vectors++; if (bus.M0_AWREADY !== 1'b1) begin miscompares++; $display("FAIL midrst_m0_awready: got %b want 1", bus.M0_AWREADY); end
        ARESETN = 1'b0;
        clear_inputs();
        @(negedge ACLK);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        ARESETN     = 1'b0;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_single_m0();
        test_burst_m1();
        test_len_short();
        test_len_long();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
